// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - field-bundle in / instruction-word out bundle for instr_encoder
// Ports: clear (stream restart), in_* field bundle with valid/ready,
//        out_* encoded word with valid/ready and byte address, done/err status.
// master = producer/sink side (bench, boot loader), slave = encoder side.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_alt;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              done;
  logic              err;

  modport master (
    output clear, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, done, err
  );

  modport slave (
    input  clear, in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_alt, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, done, err
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I instruction word assembler with sequential-address output stream
// Ports: clk, rst (sync, active high), bus (instr_encoder_if.slave):
//        in_* decoded fields with valid/ready, out_* encoded word + byte address
//        with valid/ready, done after DEPTH words, sticky err on dropped illegal bundle.
module instr_encoder #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 256
) (
  input  logic            clk,
  input  logic            rst,
  instr_encoder_if.slave  bus
);
  localparam int               CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DEPTH - 1);

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [CNT_W-1:0]  r_wcnt;
  logic              r_done;
  logic              r_err;

  logic [31:0] w_enc;
  logic        w_illegal;
  logic [6:0]  w_f7;
  logic        w_in_ready;
  logic        w_accept;
  logic        w_emit;

  always_comb begin
    w_f7      = bus.in_alt ? 7'b0100000 : 7'b0000000;
    w_enc     = '0;
    w_illegal = 1'b0;
    case (bus.in_class)
      4'd0: w_enc = {w_f7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, OP_RTYPE};
      4'd1: begin
        // SLLI/SRLI/SRAI: shamt in [24:20], alt picks arithmetic shift
        if (bus.in_funct3 == 3'b001 || bus.in_funct3 == 3'b101)
          w_enc = {1'b0, bus.in_alt, 5'b00000, bus.in_imm[4:0], bus.in_rs1, bus.in_funct3,
                   bus.in_rd, OP_ITYPE};
        else
          w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_ITYPE};
      end
      4'd2: w_enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, OP_LOAD};
      4'd3: w_enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_imm[4:0], OP_STORE};
      4'd4: begin
        w_enc     = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                     bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
        w_illegal = bus.in_imm[0];
      end
      4'd5: begin
        w_enc     = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                     bus.in_rd, OP_JAL};
        w_illegal = bus.in_imm[0];
      end
      4'd6: w_enc = {bus.in_imm[11:0], bus.in_rs1, 3'b000, bus.in_rd, OP_JALR};
      4'd7: w_enc = {bus.in_imm[31:12], bus.in_rd, OP_LUI};
      4'd8: w_enc = {bus.in_imm[31:12], bus.in_rd, OP_AUIPC};
      default: w_illegal = 1'b1;
    endcase
  end

  // A new bundle may replace the pending word only if that word leaves this
  // cycle and is not the final one; otherwise it would outlive done.
  assign w_in_ready = !rst && !bus.clear && !r_done &&
                      (!r_out_valid || (bus.out_ready && (r_wcnt < LAST)));
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_emit     = r_out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= '0;
      r_wcnt      <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_emit) begin
        r_out_addr <= r_out_addr + ADDR_W'(4);
        r_wcnt     <= r_wcnt + CNT_W'(1);
        if (r_wcnt == LAST) r_done <= 1'b1;
      end
      // An illegal bundle is consumed but leaves the output stage alone.
      if (w_accept && !w_illegal) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_enc;
      end else if (w_emit) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_out_instr;
  assign bus.out_addr  = r_out_addr;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Assembles RV32I instruction words from decoded fields: instruction class, register indices, funct3, alt bit and immediate. It is the inverse of the control/decode path. Encoded words stream out over a valid/ready handshake with a sequential byte address. The intended sink is the instruction-memory write port, so a bench or boot loader can fill program memory before releasing the CPU.

Parameters:
ADDR_W, 10, byte-address width of out_addr; DEPTH*4 must be <= 2**ADDR_W
DEPTH, 256, number of words to emit before done

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous restart of the stream (pointer, done, err, pending word)
in_valid  input  1  field bundle valid
in_ready  output  1  encoder can accept the bundle this cycle
in_class  input  4  0=RTYPE 1=ITYPE 2=LOAD 3=STORE 4=BRANCH 5=JAL 6=JALR 7=LUI 8=AUIPC; 9..15 illegal
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_alt  input  1  selects funct7=0100000 (SUB/SRA/SRAI)
in_imm  input  32  immediate, byte offset for BRANCH/JAL, full upper value for LUI/AUIPC
out_valid  output  1  encoded word pending
out_ready  input  1  sink accepts
out_instr  output  32  encoded instruction
out_addr  output  ADDR_W  byte address of out_instr (word index * 4)
done  output  1  DEPTH words have been emitted
err  output  1  sticky: an illegal bundle was dropped

Behaviour:
- Reset (rst=1): out_valid=0, out_instr=0, out_addr=0, done=0, err=0, word counter=0. in_ready is 0 during reset.
- One-entry registered output stage.
  - Accept occurs when in_valid && in_ready. The encoded word appears on out_instr with out_valid=1 the next cycle (latency 1).
  - in_ready = !rst && !clear && !done && (!out_valid || (out_ready && wcnt < DEPTH-1)). Back-to-back throughput is 1 word per cycle.
  - out_instr is held stable while out_valid && !out_ready.
- Emit occurs when out_valid && out_ready.
  - out_addr += 4 and wcnt += 1.
  - If wcnt was DEPTH-1: done=1 and out_valid=0. done holds until rst or clear, and out_addr stays at DEPTH*4 (truncated to ADDR_W).
- Encoding. Opcodes are bits [6:0]:
  - RTYPE: {f7,rs2,rs1,f3,rd,0110011}, with f7=alt?0100000:0000000.
  - ITYPE: {imm[11:0],rs1,f3,rd,0010011}. If f3 is 001 or 101, bits [31:25] become {0,alt,00000} and bits [24:20]=imm[4:0].
  - LOAD: same layout as ITYPE, opcode 0000011, no shift rule.
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
  - JALR: {imm[11:0],rs1,000,rd,1100111}; funct3 is forced to 000.
  - LUI: {imm[31:12],rd,0110111}.
  - AUIPC: {imm[31:12],rd,0010111}.
  - Unused fields are ignored. Immediate bits beyond the format are truncated without error.
- Illegal bundles: class 9..15, or BRANCH/JAL with imm[0]=1.
  - The bundle is still consumed (in_ready unaffected), err is set to 1 (sticky), and nothing is emitted.
  - out_addr does not advance and out_valid is unchanged.
- clear=1: out_valid=0, out_addr=0, wcnt=0, done=0, err=0, the pending word is discarded, and no accept occurs that cycle. This works mid-stream and after done.
- rst has priority over clear. Both take effect on the same edge with identical results for the stream state.

Test Plan:
- ITYPE rd=1 rs1=0 f3=000 imm=5 -> out_instr=0x00500093, out_addr=0, next word at addr 4.
- RTYPE rd=3 rs1=1 rs2=2 f3=000 alt=0 -> 0x002081B3; alt=1 -> 0x402081B3. STORE rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423.
- BRANCH rs1=1 rs2=2 f3=000 imm=0xFFFFFFFC -> 0xFE208EE3. JAL rd=1 imm=8 -> 0x008000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7. Each emitted word lands at consecutive addresses 0,4,8.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> exactly one word accepted, out_instr stable, in_ready=0. Then out_ready=1 for 5 cycles -> 1 word/cycle, no loss or duplication.
- DEPTH=4, stream 6 legal bundles -> 4 emits at addrs 0,4,8,12, then done=1, in_ready=0, out_valid=0, and the last 2 bundles are never accepted. clear -> done=0, out_addr=0, and streaming resumes.
- in_class=15, then BRANCH with imm=3 -> err=1, no out_valid, out_addr unchanged. rst mid-stream with a word pending -> all outputs return to reset values the next cycle.
